// File: rtl/key_ctrl_pkg.sv
// Shared constants for the push-key edge controller: register word addresses
// and the default debounce length.
package key_ctrl_pkg;

  // Default debounce length: 1 ms of stable level at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  // Avalon word addresses of the PIO-compatible register map.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

endpackage : key_ctrl_pkg

// File: rtl/key_debounce.sv
// Single key line: two-flop synchroniser, debounce counter, accepted (stable)
// level and a one-cycle press pulse on each released-to-pressed transition.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic pressed,
  output logic press
);

  // Pin level of a key that is not being pushed.
  localparam logic RELEASED = 1'(ACTIVE_LOW != 0);
  // Count value on which a differing level has been seen for DEBOUNCE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchronise the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= RELEASED;
      sync      <= RELEASED;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the value its
      // predecessor held before the edge, so this really is a 2-stage chain.
      sync_meta <= pin;
      sync      <= sync_meta;
    end
  end

  // Accept a new level only after it has been seen unbroken for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RELEASED;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        press  <= (sync != RELEASED);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = stable ^ RELEASED;

endmodule : key_debounce

// File: rtl/key_edge_ctrl.sv
// Avalon-MM push-key controller with the input-PIO register map: debounced
// key state, interrupt mask and sticky write-1-to-clear press capture.
module key_edge_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] key_pressed;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [31:0]      rd_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_key_debounce (
      .clk     (clk),
      .reset   (reset),
      .pin     (in_port[i]),
      .pressed (key_pressed[i]),
      .press   (key_press[i])
    );
  end

  // Writedata bits above the key lanes have no register behind them.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
    end else if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky press capture; a press arriving with a clear on the same bit keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecapture <= '0;
    end else if (wr_en && (address == ADDR_EDGE)) begin
      edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | key_press;
    end else begin
      edgecapture <= edgecapture | key_press;
    end
  end

  // Read mux; an unselected slave presents zero.
  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    rd_mux[WIDTH-1:0] = key_pressed;
        ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
        ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
        default:      rd_mux = '0;
      endcase
    end
  end

  // Registered read data, one cycle of read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule : key_edge_ctrl

// File: tb/tb_key_edge_ctrl.sv
// Self-checking bench for key_edge_ctrl (DEBOUNCE_CYCLES=4, WIDTH=2, active-low keys):
// register-map vector table, directed latency/corner sequences, then random
// stimulus against a sample-window reference model.
module tb_key_edge_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  key_edge_ctrl #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
    d = readdata;
    idle();
  endtask

  // Reference model: a key's accepted level flips once the D pin samples that
  // reached the synchroniser output (taken 2..D+1 edges ago) all show the other level.
  logic [1:0]  m_hist [0:D+1];
  logic [1:0]  m_stable, m_press, m_ec, m_mask;
  logic [31:0] m_rd, m_rd_next;
  logic        m_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= D + 1; k++) m_hist[k] = 2'b11;
      m_stable = 2'b11;
      m_press  = 2'b00;
      m_ec     = 2'b00;
      m_mask   = 2'b00;
      m_rd     = 32'h0;
    end else begin
      m_rd_next = 32'h0;
      if (chipselect) begin
        case (address)
          2'd0:    m_rd_next = {30'h0, ~m_stable};
          2'd2:    m_rd_next = {30'h0, m_mask};
          2'd3:    m_rd_next = {30'h0, m_ec};
          default: m_rd_next = 32'h0;
        endcase
      end
      if (chipselect && !write_n && address == 2'd3) m_ec = m_ec & ~writedata[1:0];
      m_ec = m_ec | m_press;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
      for (int k = D + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = in_port;
      m_press = 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_all = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (m_hist[k][i] == m_stable[i]) m_all = 1'b0;
        if (m_all) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i] == 1'b0) m_press[i] = 1'b1;
        end
      end
      m_rd = m_rd_next;
    end
  end

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  initial begin
    logic [31:0] rd;

    // Register-map vectors with both keys released; exp_rd is the read of that cycle.
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h3, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_00FF, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 32'h3,        32'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h3, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0, 1'b0};

    // 1: reset with keys released
    reset   = 1'b1;
    in_port = 2'b11;
    idle();
    step(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      chipselect = tbl[v].cs;
      write_n    = ~tbl[v].wr;
      address    = tbl[v].addr;
      writedata  = tbl[v].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_rd", v), readdata, tbl[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'h0, irq}, {31'h0, tbl[v].exp_irq});
    end
    idle();

    // 2: clean press of key 0; DATA visible on readdata after edge 2+D+1
    in_port    = 2'b10;
    chipselect = 1'b1;
    address    = 2'd0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check($sformatf("press_data_e%0d", e), readdata, (e >= 7) ? 32'h1 : 32'h0);
      check($sformatf("press_irq_e%0d", e), {31'h0, irq}, 32'h0);
    end
    idle();
    bus_read(2'd3, rd);
    check("press_edge", rd, 32'h1);

    // 3: bounce on key 0, then hold pressed
    in_port = 2'b11;
    step(8);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    check("bounce_pre_clear", rd, 32'h0);
    in_port[0] = 1'b0; step(2);
    in_port[0] = 1'b1; step(2);
    in_port[0] = 1'b0;
    chipselect = 1'b1;
    address    = 2'd3;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      check($sformatf("bounce_edge_e%0d", e), readdata, (e >= 8) ? 32'h1 : 32'h0);
    end
    idle();
    bus_write(2'd3, 32'h1);
    step(10);
    bus_read(2'd3, rd);
    check("bounce_single_capture", rd, 32'h0);

    // 4: interrupt path on key 1
    bus_write(2'd2, 32'h3);
    in_port = 2'b00;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check($sformatf("irq_e%0d", e), {31'h0, irq}, (e >= 7) ? 32'h1 : 32'h0);
    end
    bus_write(2'd3, 32'h2);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("edge_after_w1c", rd, 32'h0);
    bus_read(2'd0, rd);
    check("data_both_pressed", rd, 32'h3);

    // 5: W1C on the same edge as the press pulse of key 0
    in_port[0] = 1'b1;
    step(8);
    in_port[0] = 1'b0;
    step(6);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    check("collision_set_wins", rd, 32'h1);
    check("collision_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h0);
    check("mask_clear_irq", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("mask_clear_keeps_edge", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    check("w1c_clears", rd, 32'h0);

    // 6: reset in the middle of key 0's debounce
    in_port = 2'b11;
    step(8);
    bus_write(2'd2, 32'h3);
    in_port = 2'b01;
    step(8);
    in_port = 2'b11;
    step(8);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    in_port = 2'b10;
    step(3);
    reset = 1'b1;
    #1;
    check("mid_reset_irq", {31'h0, irq}, 32'h0);
    step(2);
    check("mid_reset_readdata", readdata, 32'h0);
    chipselect = 1'b1;
    address    = 2'd2;
    reset      = 1'b0;
    @(negedge clk);
    check("post_reset_mask", readdata, 32'h0);
    address = 2'd3;
    for (int e = 2; e <= 10; e++) begin
      @(negedge clk);
      check($sformatf("post_reset_edge_e%0d", e), readdata, (e >= 8) ? 32'h1 : 32'h0);
    end
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    idle();

    // Random stimulus against the reference model, with occasional resets
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd_readdata", readdata, m_rd);
      check("rnd_irq", {31'h0, irq}, {31'h0, |(m_ec & m_mask)});
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
    end
    reset = 1'b0;
    idle();
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_key_edge_ctrl
